// File: rtl/button_event_decoder.sv
// Classifies a clean button level into short, double, long and auto-repeat event pulses.
// Latency: every output is registered; a pulse appears one clock after the sample that triggers it.
// Backpressure: none; the decoder reacts to every sample and each pulse lasts exactly one cycle.
module button_event_decoder #(
  parameter int LONG_TIME   = 1000, // consecutive high samples for a long press (>= 2)
  parameter int DOUBLE_GAP  = 300,  // consecutive low samples that close the double-press window (>= 2)
  parameter int REPEAT_TIME = 200,  // repeat pulse period while held (>= 2)
  parameter int CNT_W       = 32    // duration counter width; all times must be < 2**CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic active,
  output logic held
);

  // Terminal counts: the counter starts at 1 on entry, so the Nth sample sees N-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             short_nxt;
  logic             double_nxt;
  logic             long_nxt;
  logic             repeat_nxt;

  // Next state, shared duration counter and pulse requests from the current state and level.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i) begin
          state_nxt = PRESS1;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS1: begin
        if (!i) begin
          state_nxt = WAIT2;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT2: begin
        if (i) begin
          state_nxt = PRESS2;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == GAP_LAST) begin
          // Window closed with no second press: the first press was a lone short press.
          short_nxt = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESS2: begin
        if (!i) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end else if (cnt == LONG_LAST) begin
          // Second press turned into a hold: report the first press as short alongside the long.
          short_nxt = 1'b1;
          long_nxt  = 1'b1;
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any press in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      active       <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= short_nxt;
      double_press <= double_nxt;
      long_press   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      active       <= (state_nxt != IDLE);
      held         <= (state_nxt == HELD);
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed vector table, one hand sequence, randomized run vs reference model.
// Outputs are sampled on the falling edge; inputs change right after sampling.
// No backpressure on the DUT; every cycle is checked.
module tb_button_event_decoder;

  localparam int LT = 8;
  localparam int DG = 4;
  localparam int RT = 3;
  localparam int NCYC = 25;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i = 1'b0;
  logic short_press, double_press, long_press, repeat_pulse, active, held;

  int n_cmp = 0;
  int n_err = 0;

  button_event_decoder #(
    .LONG_TIME(LT), .DOUBLE_GAP(DG), .REPEAT_TIME(RT), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .i(i),
    .short_press(short_press), .double_press(double_press),
    .long_press(long_press), .repeat_pulse(repeat_pulse),
    .active(active), .held(held)
  );

  always #5 clk = ~clk;

  // One directed scenario: bit c of each mask is the input / expected output at cycle c.
  typedef struct {
    logic [NCYC-1:0] i_m;
    logic [NCYC-1:0] rst_m;
    logic [NCYC-1:0] sh_m;
    logic [NCYC-1:0] db_m;
    logic [NCYC-1:0] lg_m;
    logic [NCYC-1:0] rp_m;
    logic [NCYC-1:0] hd_m;
    logic [NCYC-1:0] ac_m;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int sc, input int cyc, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s scen=%0d cycle=%0d got=%b want=%b", nm, sc, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input int sc, input int cyc, input logic [5:0] exp);
    chk("short_press",  sc, cyc, short_press,  exp[5]);
    chk("double_press", sc, cyc, double_press, exp[4]);
    chk("long_press",   sc, cyc, long_press,   exp[3]);
    chk("repeat_pulse", sc, cyc, repeat_pulse, exp[2]);
    chk("held",         sc, cyc, held,         exp[1]);
    chk("active",       sc, cyc, active,       exp[0]);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Reference model in terms of press count and run lengths of the input level.
  int   m_seq;   // presses in current sequence (0 = idle)
  int   m_hi;    // length of the current high run within the sequence
  int   m_lo;    // length of the current low run after the first press
  bit   m_long;  // current press has reached LONG_TIME
  logic m_sh, m_db, m_lg, m_rp;

  task automatic model_step(input logic r, input logic iv);
    m_sh = 1'b0; m_db = 1'b0; m_lg = 1'b0; m_rp = 1'b0;
    if (r) begin
      m_seq = 0; m_hi = 0; m_lo = 0; m_long = 1'b0;
    end else if (m_seq == 0) begin
      if (iv) begin m_seq = 1; m_hi = 1; m_lo = 0; end
    end else if (m_long) begin
      if (iv) begin
        m_hi++;
        if ((m_hi - LT) % RT == 0) m_rp = 1'b1;
      end else begin
        m_seq = 0; m_long = 1'b0;
      end
    end else if (iv) begin
      if (m_lo > 0) begin
        m_seq = 2; m_hi = 1; m_lo = 0;
      end else begin
        m_hi++;
        if (m_hi == LT) begin
          m_lg = 1'b1; m_long = 1'b1;
          if (m_seq == 2) m_sh = 1'b1;
        end
      end
    end else begin
      if (m_seq == 2) begin
        m_db = 1'b1; m_seq = 0;
      end else begin
        m_lo++;
        if (m_lo == DG) begin m_sh = 1'b1; m_seq = 0; end
      end
    end
  endtask

  initial begin
    logic [12:0] third;
    logic        lvl;
    int          run_left;
    logic        r;

    // short press
    vecs[0] = '{i_m: 25'h0000007, rst_m: '0, sh_m: 25'h0000080, db_m: '0, lg_m: '0,
                rp_m: '0, hd_m: '0, ac_m: 25'h000007E};
    // double press
    vecs[1] = '{i_m: 25'h0000033, rst_m: '0, sh_m: '0, db_m: 25'h0000080, lg_m: '0,
                rp_m: '0, hd_m: '0, ac_m: 25'h000007E};
    // long press with repeats, then release
    vecs[2] = '{i_m: 25'h00FFFFF, rst_m: '0, sh_m: '0, db_m: '0, lg_m: 25'h0000100,
                rp_m: 25'h0124800, hd_m: 25'h01FFF00, ac_m: 25'h01FFFFE};
    // second press held: short and long coincide
    vecs[3] = '{i_m: 25'h1FFFFF3, rst_m: '0, sh_m: 25'h0001000, db_m: '0, lg_m: 25'h0001000,
                rp_m: 25'h1248000, hd_m: 25'h1FFF000, ac_m: 25'h1FFFFFE};
    // window expiry exactly at the new press: short, then a fresh single press
    vecs[4] = '{i_m: 25'h0000043, rst_m: '0, sh_m: 25'h0000840, db_m: '0, lg_m: '0,
                rp_m: '0, hd_m: '0, ac_m: 25'h00007BE};
    // reset mid-press: new press counts from cycle 6
    vecs[5] = '{i_m: 25'h1FFFFFF, rst_m: 25'h0000020, sh_m: '0, db_m: '0, lg_m: 25'h0004000,
                rp_m: 25'h0920000, hd_m: 25'h1FFC000, ac_m: 25'h1FFFFBE};

    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      reset_dut();
      for (int c = 0; c < NCYC; c++) begin
        chk_all(k, c, {vecs[k].sh_m[c], vecs[k].db_m[c], vecs[k].lg_m[c],
                       vecs[k].rp_m[c], vecs[k].hd_m[c], vecs[k].ac_m[c]});
        reset = vecs[k].rst_m[c];
        i     = vecs[k].i_m[c];
        @(negedge clk);
      end
    end

    // Third press after a double press starts a new sequence from idle.
    third = 13'b0000010110011;
    reset_dut();
    for (int c = 0; c < 13; c++) begin
      if (c == 7) begin
        chk("third_dbl", 6, c, double_press, 1'b1);
        chk("third_idle", 6, c, active, 1'b0);
      end
      if (c == 8) begin
        chk("third_active", 6, c, active, 1'b1);
        chk("third_nodbl", 6, c, double_press, 1'b0);
      end
      if (c == 12) chk("third_short", 6, c, short_press, 1'b1);
      reset = 1'b0;
      i     = third[c];
      @(negedge clk);
    end

    // Randomized runs of high/low levels with occasional resets, checked against the model.
    reset = 1'b1;
    i = 1'b0;
    model_step(1'b1, 1'b0);
    lvl = 1'b0;
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      chk_all(100, c, {m_sh, m_db, m_lg, m_rp, m_long, (m_seq != 0)});
      if (run_left == 0) begin
        lvl = ~lvl;
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 5);
      end
      run_left--;
      r = ($urandom_range(0, 299) == 0);
      reset = r;
      i = lvl;
      model_step(r, lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced, glitch-filtered level from the glitch filter stage (active-high = pressed).
- Classifies press activity into single-cycle event pulses: short press, double press, long press, and auto-repeat while held.
- Sits between the input conditioning chain and the control/register logic that reacts to user buttons.
- Level-based FSM with one shared duration counter. Has no edge-detect register of its own; input is already clean.

Parameters:
- LONG_TIME, 1000: consecutive high samples that qualify a long press; must be >= 2.
- DOUBLE_GAP, 300: consecutive low samples after a short press that close the double-press window; must be >= 2.
- REPEAT_TIME, 200: period in cycles of repeat pulses while held after a long press; must be >= 2.
- CNT_W, 32: counter width; all of the time parameters must be < 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i  input  1  filtered button level, 1 = pressed.
- short_press  output  1  one-cycle pulse: single short press completed.
- double_press  output  1  one-cycle pulse: two short presses within the gap.
- long_press  output  1  one-cycle pulse: press held LONG_TIME samples.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_TIME cycles in HELD.
- active  output  1  registered; 1 whenever state != IDLE.
- held  output  1  registered; 1 when state == HELD.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state = IDLE, cnt = 0, all outputs 0 on the next edge.
  - Reset mid-press discards the press. If i is still 1 after reset release, it counts as a new press from the first sampled high.
- All outputs are registered. Each pulse is high for exactly 1 cycle, visible on the edge after its firing condition is sampled.
- States and transitions (i is the sampled level, cnt counts samples):
  - IDLE: if i=1 -> PRESS1, cnt=1.
  - PRESS1: evaluated in this priority order:
    - if i=0 -> WAIT2, cnt=1.
    - else if cnt==LONG_TIME-1 -> fire long_press, go to HELD, cnt=0.
    - else cnt+1.
  - WAIT2:
    - if i=1 -> PRESS2, cnt=1.
    - else if cnt==DOUBLE_GAP-1 -> fire short_press, go to IDLE.
    - else cnt+1.
  - PRESS2:
    - if i=0 -> fire double_press, go to IDLE.
    - else if cnt==LONG_TIME-1 -> fire short_press AND long_press in the same cycle, go to HELD, cnt=0.
    - else cnt+1.
  - HELD:
    - if i=0 -> IDLE, no pulse.
    - else if cnt==REPEAT_TIME-1 -> fire repeat_pulse, cnt=0.
    - else cnt+1.
- Resulting timing rules:
  - Long press = LONG_TIME consecutive high samples.
  - Short press is reported only after DOUBLE_GAP consecutive low samples, so it is delayed by the double-press window.
  - First repeat_pulse arrives REPEAT_TIME cycles after long_press, then every REPEAT_TIME cycles.
- At most one of short/double/repeat fires per cycle. The only permitted coincidence is short_press with long_press, from PRESS2.
- The counter never exceeds max(LONG_TIME, DOUBLE_GAP, REPEAT_TIME)-1, so no wrap-around is possible.
- A third press arriving after double_press starts a new sequence from IDLE.
- active and held update on the same edge as the state register.

Test Plan:
All scenarios use LONG_TIME=8, DOUBLE_GAP=4, REPEAT_TIME=3; cycle 0 is the first sampled i=1 after reset.
- Short press: i=1 for cycles 0-2, then 0 -> short_press high only at cycle 7. No other pulses. active falls at cycle 7.
- Double press: i=1 for cycles 0-1, 0 for 2-3, 1 for 4-5, 0 from 6 -> double_press high only at cycle 7. short_press never fires.
- Long press + repeat: i=1 for cycles 0-19, then 0 -> long_press at cycle 8, repeat_pulse at 11, 14, 17, 20. held is 1 for cycles 8-20, then 0 at 21 with no pulse.
- Second press held: i=1 for 0-1, 0 for 2-3, 1 from 4 onward -> short_press and long_press both high at cycle 12. held=1 from cycle 12.
- Window expiry boundary: i=1 for 0-1, then 0 for exactly 4 cycles (2-5), then 1 at 6 -> short_press at cycle 6. The new press goes IDLE->PRESS1, with no double_press.
- Reset mid-operation: i=1 from cycle 0, reset=1 at cycle 5 for one cycle -> all outputs 0 at cycle 6. A new press counts from cycle 6, so long_press fires at cycle 14.
